// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR engine: FSM state encoding and step-form selectors.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lfsr_state_e;

    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_GAL = 1'b1;

endpackage

// File: rtl/lfsr_step.sv
// Single combinational LFSR step in Fibonacci or Galois form; kept standalone so it can be
// chained for multi-step unrolling.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int unsigned         WIDTH = 32,
    parameter logic [WIDTH-1:0]    TAPS  = 32'h8020_0003
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] next_state_o
);

    logic             fib_fb;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;

    always_comb begin
        fib_fb   = ^(state_i & TAPS);
        fib_next = {state_i[WIDTH-2:0], fib_fb};
        gal_next = (state_i >> 1) ^ (state_i[0] ? TAPS : '0);
    end

    always_comb begin
        next_state_o = fib_next;
        if (mode_i == MODE_GAL) begin
            next_state_o = gal_next;
        end
    end

endmodule

// File: rtl/lfsr_engine.sv
// Width-generic LFSR sequence engine: seed load, N-step run under start/busy/done handshake,
// sticky lockup flag on zero-seed loads.
module lfsr_engine
    import lfsr_pkg::*;
#(
    parameter int unsigned         WIDTH      = 32,
    parameter logic [WIDTH-1:0]    TAPS       = 32'h8020_0003,
    parameter int unsigned         CNT_W      = 16,
    parameter logic [WIDTH-1:0]    RESET_SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    input  logic [WIDTH-1:0] seed,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic             lockup,
    output logic [WIDTH-1:0] result
);

    lfsr_state_e      fsm_q,    fsm_d;
    logic [WIDTH-1:0] state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             mode_q,   mode_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] step_next;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .state_i      (state_q),
        .mode_i       (mode_q),
        .next_state_o (step_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= IDLE;
            state_q  <= RESET_SEED;
            cnt_q    <= '0;
            mode_q   <= MODE_FIB;
            lockup_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            lockup_q <= lockup_d;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        lockup_d = lockup_q;

        case (fsm_q)
            IDLE: begin
                // A seed load takes priority; a coincident start is dropped.
                if (seed_valid) begin
                    if (seed == '0) begin
                        state_d  = RESET_SEED;
                        lockup_d = 1'b1;
                    end else begin
                        state_d  = seed;
                        lockup_d = 1'b0;
                    end
                end else if (start) begin
                    cnt_d  = count;
                    mode_d = mode;
                    fsm_d  = (count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                state_d = step_next;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy   = (fsm_q == RUN);
        done   = (fsm_q == DONE);
        lockup = lockup_q;
        result = state_q;
    end

endmodule

// File: tb/tb_lfsr_engine.sv
// Directed bench for lfsr_engine at WIDTH=8, TAPS=8'hB8, CNT_W=8 with hand-computed sequences.
module tb_lfsr_engine;

    logic       clk;
    logic       rst;
    logic       seed_valid;
    logic [7:0] seed;
    logic       start;
    logic [7:0] count;
    logic       mode;
    logic       busy;
    logic       done;
    logic       lockup;
    logic [7:0] result;

    int unsigned n_cmp;
    int unsigned n_err;

    lfsr_engine #(
        .WIDTH      (8),
        .TAPS       (8'hB8),
        .CNT_W      (8),
        .RESET_SEED (8'h01)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed       (seed),
        .start      (start),
        .count      (count),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .lockup     (lockup),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [7:0] s);
        seed_valid = 1'b1;
        seed       = s;
        tick();
        seed_valid = 1'b0;
    endtask

    task automatic issue_start(input logic [7:0] n, input logic m);
        start = 1'b1;
        count = n;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    logic [7:0] fib_seq [4];
    logic [7:0] gal_seq [2];

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        seed_valid = 1'b0;
        seed       = '0;
        start      = 1'b0;
        count      = '0;
        mode       = 1'b0;
        fib_seq    = '{8'h01, 8'h02, 8'h04, 8'h08};
        gal_seq    = '{8'h01, 8'hB8};

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_result", 32'(result), 32'h01);
        check_eq("rst_busy",   32'(busy),   32'h0);
        check_eq("rst_done",   32'(done),   32'h0);
        check_eq("rst_lockup", 32'(lockup), 32'h0);
        rst = 1'b0;
        tick();

        // Fibonacci: 01 -> 02 -> 04 -> 08 -> 11
        load_seed(8'h01);
        check_eq("fib_seed", 32'(result), 32'h01);
        issue_start(8'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_eq("fib_busy",   32'(busy),   32'h1);
            check_eq("fib_nodone", 32'(done),   32'h0);
            check_eq("fib_step",   32'(result), 32'(fib_seq[i]));
            tick();
        end
        check_eq("fib_done",      32'(done),   32'h1);
        check_eq("fib_done_busy", 32'(busy),   32'h0);
        check_eq("fib_final",     32'(result), 32'h11);
        tick();
        check_eq("fib_done_1cyc", 32'(done),   32'h0);
        check_eq("fib_hold",      32'(result), 32'h11);

        // Galois: 01 -> B8 -> 5C
        load_seed(8'h01);
        issue_start(8'd2, 1'b1);
        for (int i = 0; i < 2; i++) begin
            check_eq("gal_busy", 32'(busy),   32'h1);
            check_eq("gal_step", 32'(result), 32'(gal_seq[i]));
            tick();
        end
        check_eq("gal_done",      32'(done),   32'h1);
        check_eq("gal_final",     32'(result), 32'h5C);
        tick();
        check_eq("gal_done_1cyc", 32'(done),   32'h0);

        // Zero seed substitutes RESET_SEED and sets sticky lockup
        load_seed(8'h00);
        check_eq("zs_result", 32'(result), 32'h01);
        check_eq("zs_lockup", 32'(lockup), 32'h1);
        tick();
        check_eq("zs_sticky", 32'(lockup), 32'h1);
        load_seed(8'h33);
        check_eq("nz_result", 32'(result), 32'h33);
        check_eq("nz_lockup", 32'(lockup), 32'h0);

        // Zero count: immediate done, no step
        issue_start(8'd0, 1'b0);
        check_eq("z_done",   32'(done),   32'h1);
        check_eq("z_busy",   32'(busy),   32'h0);
        check_eq("z_result", 32'(result), 32'h33);
        tick();
        check_eq("z_done_1cyc", 32'(done), 32'h0);

        // Seed load and start together: seed wins, no run
        seed_valid = 1'b1;
        seed       = 8'h55;
        start      = 1'b1;
        count      = 8'd3;
        tick();
        seed_valid = 1'b0;
        start      = 1'b0;
        check_eq("col_result", 32'(result), 32'h55);
        check_eq("col_busy",   32'(busy),   32'h0);
        check_eq("col_done",   32'(done),   32'h0);
        tick();
        check_eq("col_busy2",  32'(busy),   32'h0);
        check_eq("col_hold",   32'(result), 32'h55);

        // Start and seed_valid during RUN are ignored
        load_seed(8'h01);
        issue_start(8'd4, 1'b0);
        tick();
        seed_valid = 1'b1;
        seed       = 8'h77;
        start      = 1'b1;
        count      = 8'd1;
        mode       = 1'b1;
        tick();
        tick();
        seed_valid = 1'b0;
        start      = 1'b0;
        check_eq("ign_busy",   32'(busy),   32'h1);
        check_eq("ign_result", 32'(result), 32'h08);
        tick();
        check_eq("ign_done",   32'(done),   32'h1);
        check_eq("ign_final",  32'(result), 32'h11);
        check_eq("ign_lockup", 32'(lockup), 32'h0);
        tick();

        // Asynchronous reset mid-run: lockup set beforehand to see it clear
        load_seed(8'h00);
        issue_start(8'd200, 1'b0);
        repeat (50) tick();
        check_eq("mr_busy_pre", 32'(busy),   32'h1);
        check_eq("mr_lock_pre", 32'(lockup), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("mr_result", 32'(result), 32'h01);
        check_eq("mr_busy",   32'(busy),   32'h0);
        check_eq("mr_done",   32'(done),   32'h0);
        check_eq("mr_lockup", 32'(lockup), 32'h0);
        tick();
        tick();
        check_eq("mr_nodone", 32'(done), 32'h0);
        rst = 1'b0;
        tick();
        check_eq("mr_nodone2", 32'(done), 32'h0);
        check_eq("mr_idle",    32'(busy), 32'h0);

        load_seed(8'h01);
        issue_start(8'd4, 1'b0);
        repeat (4) tick();
        check_eq("post_done",   32'(done),   32'h1);
        check_eq("post_result", 32'(result), 32'h11);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
